fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding unit for the pipelined LC-3b core.
- Tracks in-flight register writers in an internal shift register that mirrors the back-end pipeline stages, by default EX, MEM and WB.
- For each source operand port it selects the youngest in-flight result or the register-file value.
- Raises a stall when the matching producer has not yet produced its data, e.g. a load still in EX.

Parameters:
- WIDTH, 16, data width.
- REG_BITS, 3, register index width.
- NUM_STAGES, 3, tracked stages; index 0 is the youngest (EX).
- NUM_SRC, 2, number of source operand ports.
- CNT_BITS, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- advance  in  1  pipeline moves one stage this cycle.
- flush  in  1  discard all tracked entries.
- ins_valid  in  1  instruction leaving decode is real (0 = bubble).
- ins_regwrite  in  1  that instruction writes a register.
- ins_dest  in  REG_BITS  its destination register.
- stage_data  in  NUM_STAGES*WIDTH  result currently held by stage k, packed k*WIDTH.
- stage_data_rdy  in  NUM_STAGES  stage k result is valid this cycle.
- src_reg  in  NUM_SRC*REG_BITS  source register indices.
- rf_data  in  NUM_SRC*WIDTH  register-file read data per source.
- fwd_data  out  NUM_SRC*WIDTH  operand value per source.
- fwd_hit  out  NUM_SRC  source was satisfied from a stage.
- stall  out  1  some source depends on a not-ready producer.
- stall_count  out  CNT_BITS  saturating count of stall cycles.

Behaviour:
- Entry k holds the registered fields {vld, dest}.
  - vld = ins_valid & ins_regwrite at insertion.
- Reset (reset_n=0 at a clk edge):
  - all vld=0, dest=0, stall_count=0.
  - Outputs therefore read fwd_hit=0, stall=0, fwd_data=rf_data.
  - Reset dominates flush and advance, and is valid mid-operation.
- flush=1 (no reset): all vld<=0 next cycle, regardless of advance. The decode instruction is also dropped.
- advance=1, no flush:
  - entry0 <= {ins_valid&ins_regwrite, ins_dest}.
  - entry k <= entry k-1.
  - entry NUM_STAGES-1 retires.
- advance=0: entries hold unchanged.
- Lookup is combinational, zero latency, per source s:
  - Scan k=0..NUM_STAGES-1 and select the lowest k with vld[k] && dest[k]==src_reg[s]. The youngest writer wins.
  - Match with stage_data_rdy[k]=1: fwd_data[s]=stage_data[k], fwd_hit[s]=1.
  - Match with stage_data_rdy[k]=0: fwd_hit[s]=0, fwd_data[s]=rf_data[s], source contributes to stall. Older ready matches are NOT used.
  - No match: fwd_data[s]=rf_data[s], fwd_hit[s]=0.
- All register indices are real; R0 is not special.
- stall = OR of per-source not-ready conditions.
- Stall handling is the controller's job: it deasserts advance (or bubbles EX) while stall=1. The block does not gate advance itself.
- stall_count increments on each clk edge with stall=1 and reset_n=1. It saturates at all-ones and clears only on reset.
- Two sources may match the same entry; each resolves independently.

Test Plan:
1. Reset, then src_reg={R1,R2}, rf_data={0x1111,0x2222} -> fwd_data={0x1111,0x2222}, fwd_hit=00, stall=0, stall_count=0.
2. Insert ADD R3 (advance=1); next cycle src0=R3, stage_data[0]=0x00A5, rdy[0]=1 -> fwd_data[0]=0x00A5, fwd_hit[0]=1, stall=0.
3. Insert R3 then R3 again on consecutive cycles; stage0=0xBEEF rdy, stage1=0x1234 rdy -> fwd_data[0]=0xBEEF (youngest wins).
4. LDR R4 in stage 0 with rdy[0]=0, src1=R4, advance=0 for 2 cycles -> stall=1 both cycles, stall_count=2. Then advance=1 with rdy[1]=1, stage_data[1]=0x0F0F -> stall=0, fwd_data[1]=0x0F0F.
5. Entries R5 valid in all stages, flush=1 together with advance=1 and ins_dest=R5 -> next cycle src0=R5 gives fwd_hit=0, fwd_data=rf_data.
6. Hold stall=1 for 2^CNT_BITS+3 cycles (CNT_BITS=4 build) -> stall_count saturates at 0xF. reset_n=0 mid-stall -> stall_count=0 and all entries invalid next cycle.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand-forwarding unit for the pipelined LC-3b core. It keeps a short
//   shift register of in-flight register writers that mirrors the back-end
//   stages (entry 0 = EX, the youngest). For each source operand it returns the
//   youngest in-flight result, or the register-file value when nothing
//   matches. A stall is raised while the youngest matching producer has no
//   data yet.
//
// Ports
//   clk, reset_n       clock, synchronous active-low reset
//   advance, flush     pipeline step / discard every tracked entry
//   ins_valid, ins_regwrite, ins_dest
//                      instruction leaving decode (inserted on advance)
//   stage_data, stage_data_rdy
//                      per-stage result and its valid flag, stage k at k*WIDTH
//   src_reg, rf_data   per-source register index and register-file data
//   fwd_data, fwd_hit  per-source operand value, and "came from a stage"
//   stall              some source waits on a producer that is not ready
//   stall_count        saturating count of stalled cycles
module fwd_scoreboard #(
  parameter int WIDTH      = 16,
  parameter int REG_BITS   = 3,
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int CNT_BITS   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          advance,
  input  logic                          flush,
  input  logic                          ins_valid,
  input  logic                          ins_regwrite,
  input  logic [REG_BITS-1:0]           ins_dest,
  input  logic [NUM_STAGES*WIDTH-1:0]   stage_data,
  input  logic [NUM_STAGES-1:0]         stage_data_rdy,
  input  logic [NUM_SRC*REG_BITS-1:0]   src_reg,
  input  logic [NUM_SRC*WIDTH-1:0]      rf_data,
  output logic [NUM_SRC*WIDTH-1:0]      fwd_data,
  output logic [NUM_SRC-1:0]            fwd_hit,
  output logic                          stall,
  output logic [CNT_BITS-1:0]           stall_count
);

  logic [NUM_STAGES-1:0]                vld_q, vld_d;
  logic [NUM_STAGES-1:0][REG_BITS-1:0]  dest_q, dest_d;
  logic [CNT_BITS-1:0]                  cnt_q, cnt_d;
  logic [NUM_SRC-1:0]                   wait_s;

  // Writer tracking. Flush only clears the valid bits; stale dest values are
  // harmless because lookup qualifies every compare with vld.
  always_comb begin
    vld_d  = vld_q;
    dest_d = dest_q;
    if (flush) begin
      vld_d = '0;
    end else if (advance) begin
      vld_d[0]  = ins_valid & ins_regwrite;
      dest_d[0] = ins_dest;
      for (int k = 1; k < NUM_STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
    end
  end

  // Lookup scans from the oldest stage down to stage 0, so a younger match
  // overwrites an older one and the youngest writer wins. A not-ready
  // youngest match falls back to rf_data and hides any older ready match.
  always_comb begin
    fwd_data = rf_data;
    fwd_hit  = '0;
    wait_s   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (vld_q[k] && (dest_q[k] == src_reg[s*REG_BITS +: REG_BITS])) begin
          if (stage_data_rdy[k]) begin
            fwd_data[s*WIDTH +: WIDTH] = stage_data[k*WIDTH +: WIDTH];
            fwd_hit[s]                 = 1'b1;
            wait_s[s]                  = 1'b0;
          end else begin
            fwd_data[s*WIDTH +: WIDTH] = rf_data[s*WIDTH +: WIDTH];
            fwd_hit[s]                 = 1'b0;
            wait_s[s]                  = 1'b1;
          end
        end
      end
    end
  end

  assign stall = |wait_s;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_BITS{1'b1}})) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  assign stall_count = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= '0;
      dest_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      dest_q <= dest_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  localparam int W    = 16;
  localparam int RB   = 3;
  localparam int NS   = 3;
  localparam int NSRC = 2;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 advance;
  logic                 flush;
  logic                 ins_valid;
  logic                 ins_regwrite;
  logic [RB-1:0]        ins_dest;
  logic [NS*W-1:0]      stage_data;
  logic [NS-1:0]        stage_data_rdy;
  logic [NSRC*RB-1:0]   src_reg;
  logic [NSRC*W-1:0]    rf_data;
  logic [NSRC*W-1:0]    fwd_data;
  logic [NSRC-1:0]      fwd_hit;
  logic                 stall;
  logic [CB-1:0]        stall_count;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .WIDTH(W), .REG_BITS(RB), .NUM_STAGES(NS), .NUM_SRC(NSRC), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
    .ins_valid(ins_valid), .ins_regwrite(ins_regwrite), .ins_dest(ins_dest),
    .stage_data(stage_data), .stage_data_rdy(stage_data_rdy),
    .src_reg(src_reg), .rf_data(rf_data),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall),
    .stall_count(stall_count)
  );

  // Reference model: a queue of in-flight writers, front = youngest.
  typedef struct {
    bit            vld;
    logic [RB-1:0] dest;
  } ent_t;

  ent_t             pipe[$];
  int               exp_cnt;
  logic [NSRC*W-1:0] exp_data;
  logic [NSRC-1:0]  exp_hit;
  logic             exp_stall;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    pipe = {};
    for (int i = 0; i < NS; i++) pipe.push_back('{vld: 1'b0, dest: '0});
  endtask

  // Called at negedge+0 after inputs are set; compares all outputs to model.
  task automatic sample_check();
    #1;
    exp_data  = rf_data;
    exp_hit   = '0;
    exp_stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      for (int k = 0; k < NS; k++) begin
        if (pipe[k].vld && pipe[k].dest == src_reg[s*RB +: RB]) begin
          if (stage_data_rdy[k]) begin
            exp_data[s*W +: W] = stage_data[k*W +: W];
            exp_hit[s]         = 1'b1;
          end else begin
            exp_stall = 1'b1;
          end
          break;
        end
      end
    end
    check("fwd_data", 64'(fwd_data), 64'(exp_data));
    check("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
    check("stall", 64'(stall), 64'(exp_stall));
    check("stall_count", 64'(stall_count), 64'(exp_cnt));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
      exp_cnt = 0;
    end else begin
      if (exp_stall && exp_cnt < CMAX) exp_cnt++;
      if (flush) begin
        foreach (pipe[i]) pipe[i].vld = 1'b0;
      end else if (advance) begin
        pipe.push_front('{vld: (ins_valid && ins_regwrite), dest: ins_dest});
        void'(pipe.pop_back());
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample_check();
    clock_edge();
  endtask

  task automatic idle_inputs();
    reset_n        = 1'b1;
    advance        = 1'b0;
    flush          = 1'b0;
    ins_valid      = 1'b0;
    ins_regwrite   = 1'b0;
    ins_dest       = '0;
    stage_data     = '0;
    stage_data_rdy = '0;
    src_reg        = {3'd2, 3'd1};
    rf_data        = {16'h2222, 16'h1111};
  endtask

  task automatic insert(input logic [RB-1:0] d);
    advance      = 1'b1;
    ins_valid    = 1'b1;
    ins_regwrite = 1'b1;
    ins_dest     = d;
    cycle();
    advance      = 1'b0;
    ins_valid    = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_clear();
    exp_cnt   = 0;
    exp_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // 1: reset state
    cycle();
    reset_n = 1'b1;
    sample_check();
    check("t1_data", 64'(fwd_data), 64'h2222_1111);
    check("t1_hit", 64'(fwd_hit), 64'd0);
    check("t1_cnt", 64'(stall_count), 64'd0);
    clock_edge();

    // 2: single producer forwarded from EX
    insert(3'd3);
    src_reg        = {3'd2, 3'd3};
    stage_data     = {16'h0, 16'h0, 16'h00A5};
    stage_data_rdy = 3'b001;
    sample_check();
    check("t2_data0", 64'(fwd_data[15:0]), 64'h00A5);
    check("t2_hit0", 64'(fwd_hit[0]), 64'd1);
    check("t2_stall", 64'(stall), 64'd0);
    clock_edge();

    // 3: youngest writer wins
    insert(3'd3);
    stage_data     = {16'h0, 16'h1234, 16'hBEEF};
    stage_data_rdy = 3'b011;
    sample_check();
    check("t3_youngest", 64'(fwd_data[15:0]), 64'hBEEF);
    clock_edge();

    // 4: load-use stall, then forward from MEM
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    insert(3'd4);
    src_reg        = {3'd4, 3'd7};
    stage_data_rdy = 3'b000;
    for (int i = 0; i < 2; i++) begin
      sample_check();
      check("t4_stall", 64'(stall), 64'd1);
      clock_edge();
    end
    sample_check();
    check("t4_cnt", 64'(stall_count), 64'd2);
    advance = 1'b1;
    clock_edge();
    advance        = 1'b0;
    stage_data     = {16'h0, 16'h0F0F, 16'h0};
    stage_data_rdy = 3'b010;
    sample_check();
    check("t4_stall_clr", 64'(stall), 64'd0);
    check("t4_data1", 64'(fwd_data[31:16]), 64'h0F0F);
    clock_edge();

    // 5: flush beats advance and drops the decode instruction
    for (int i = 0; i < NS; i++) insert(3'd5);
    flush        = 1'b1;
    advance      = 1'b1;
    ins_valid    = 1'b1;
    ins_regwrite = 1'b1;
    ins_dest     = 3'd5;
    cycle();
    flush          = 1'b0;
    advance        = 1'b0;
    ins_valid      = 1'b0;
    src_reg        = {3'd2, 3'd5};
    stage_data_rdy = 3'b111;
    sample_check();
    check("t5_hit", 64'(fwd_hit), 64'd0);
    check("t5_data", 64'(fwd_data), 64'(rf_data));
    clock_edge();

    // 6: saturation, then reset mid-stall
    insert(3'd6);
    src_reg        = {3'd2, 3'd6};
    stage_data_rdy = 3'b000;
    for (int i = 0; i < (1 << CB) + 3; i++) cycle();
    sample_check();
    check("t6_sat", 64'(stall_count), 64'(CMAX));
    clock_edge();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    sample_check();
    check("t6_cnt_rst", 64'(stall_count), 64'd0);
    check("t6_stall_rst", 64'(stall), 64'd0);
    check("t6_hit_rst", 64'(fwd_hit), 64'd0);
    clock_edge();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset_n        = ($urandom_range(0, 49) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      advance        = ($urandom_range(0, 2) != 0);
      ins_valid      = ($urandom_range(0, 4) != 0);
      ins_regwrite   = ($urandom_range(0, 3) != 0);
      ins_dest       = RB'($urandom_range(0, 7));
      for (int k = 0; k < NS; k++) stage_data[k*W +: W] = W'($urandom);
      stage_data_rdy = NS'($urandom);
      for (int s = 0; s < NSRC; s++) begin
        src_reg[s*RB +: RB] = RB'($urandom_range(0, 7));
        rf_data[s*W +: W]   = W'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
